// File: rtl/store_buf_if.sv
// Store buffer bus: mem_stage store port, load probe and the sys_mem write port.
// master = mem_stage/sys_mem side, slave = store_buf.
interface store_buf_if #(
    parameter int addr_w = 32
);
    logic              st_valid;
    logic [addr_w-1:0] st_addr;
    logic [31:0]       st_data;
    logic [3:0]        st_mask;
    logic              st_rdy;

    logic [addr_w-1:0] ld_addr;
    logic              ld_valid;
    logic              ld_hit;
    logic [31:0]       ld_data;
    logic              ld_stall;

    logic              wr_valid;
    logic [addr_w-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_mask;
    logic              wr_done;

    logic              empty;

    modport master (
        output st_valid, st_addr, st_data, st_mask, ld_addr, ld_valid, wr_done,
        input  st_rdy, ld_hit, ld_data, ld_stall, wr_valid, wr_addr, wr_data, wr_mask, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_mask, ld_addr, ld_valid, wr_done,
        output st_rdy, ld_hit, ld_data, ld_stall, wr_valid, wr_addr, wr_data, wr_mask, empty
    );
endinterface

// File: rtl/store_buf.sv
// In-order FIFO store buffer draining to sys_mem, with load probing.
// Optional macro STORE_BUF_FWD_EN enables forwarding of full-word matches.
module store_buf #(
    parameter int depth  = 4,
    parameter int addr_w = 32
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    store_buf_if.slave bus
);
    localparam int ptr_w = $clog2(depth);
    localparam int cnt_w = ptr_w + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state;
    state_t            state_nx;
    logic [ptr_w-1:0]  head;
    logic [ptr_w-1:0]  tail;
    logic [cnt_w-1:0]  count;

    logic [addr_w-1:0] ent_addr [depth];
    logic [31:0]       ent_data [depth];
    logic [3:0]        ent_mask [depth];

    logic              push;
    logic              pop;
    logic              match;
    logic [ptr_w-1:0]  match_idx;
    logic [ptr_w-1:0]  idx;
    logic              unused_bits;

    assign unused_bits = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

    assign bus.st_rdy = (count != cnt_w'(depth));
    assign push       = en & bus.st_valid & bus.st_rdy;
    assign pop        = en & (state == WAIT) & bus.wr_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // wr_done only retires the head while a write is actually outstanding.
    always_comb begin
        state_nx = state;
        if (en) begin
            case (state)
                IDLE:    if (count != '0) state_nx = ISSUE;
                ISSUE:   state_nx = WAIT;
                WAIT:    if (bus.wr_done) state_nx = (count > cnt_w'(1)) ? ISSUE : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + ptr_w'(1);
            if (pop)  head <= head + ptr_w'(1);
            case ({push, pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= {bus.st_addr[addr_w-1:2], 2'b00};
            ent_data[tail] <= bus.st_data;
            ent_mask[tail] <= bus.st_mask;
        end
    end

    assign bus.wr_valid = (state == ISSUE);
    assign bus.wr_addr  = ent_addr[head];
    assign bus.wr_data  = ent_data[head];
    assign bus.wr_mask  = ent_mask[head];
    assign bus.empty    = (count == '0) && (state == IDLE);

    // Walk oldest to youngest so the last hit found is the youngest store.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        idx       = '0;
        for (int k = 0; k < depth; k++) begin
            idx = head + ptr_w'(k);
            if ((cnt_w'(k) < count) &&
                (ent_addr[idx][addr_w-1:2] == bus.ld_addr[addr_w-1:2])) begin
                match     = 1'b1;
                match_idx = idx;
            end
        end
    end

`ifdef STORE_BUF_FWD_EN
    logic full_word;
    assign full_word    = (ent_mask[match_idx] == 4'hF);
    assign bus.ld_hit   = bus.ld_valid & match & full_word;
    assign bus.ld_data  = bus.ld_hit ? ent_data[match_idx] : 32'h0;
    assign bus.ld_stall = bus.ld_valid & match & ~full_word;
`else
    logic unused_fwd;
    assign unused_fwd   = ^match_idx;
    assign bus.ld_hit   = 1'b0;
    assign bus.ld_data  = 32'h0;
    assign bus.ld_stall = bus.ld_valid & match;
`endif
endmodule

// File: tb/tb_store_buf.sv
// Directed self-checking bench for store_buf (depth 4), covering both
// STORE_BUF_FWD_EN builds through the same macro.
module tb_store_buf;
    logic clk = 1'b0;
    logic rst;
    logic en;

    store_buf_if #(.addr_w(32)) bus ();

    store_buf #(.depth(4), .addr_w(32)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] issued [$];

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every write request seen on the sys_mem port is logged for order checks.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (bus.wr_valid === 1'b1) issued.push_back({bus.wr_addr, bus.wr_data});
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] m);
        bus.st_valid = v;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.st_mask  = m;
    endtask

    task automatic probe(input string tag, input logic v, input logic [31:0] a,
                         input logic hit, input logic [31:0] data, input logic stall);
        bus.ld_valid = v;
        bus.ld_addr  = a;
        #1;
        checkOutput({tag, "_hit"},   64'(bus.ld_hit),   64'(hit));
        checkOutput({tag, "_data"},  64'(bus.ld_data),  64'(data));
        checkOutput({tag, "_stall"}, 64'(bus.ld_stall), 64'(stall));
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'h0;
    endtask

    // Wait (bounded) for the next issue, then complete it with a wr_done pulse.
    task automatic finishWrite(input string tag);
        int n = 0;
        while (bus.wr_valid !== 1'b1 && n < 8) begin
            cycle();
            n++;
        end
        checkOutput({tag, "_issue"}, 64'(bus.wr_valid), 64'd1);
        cycle();
        bus.wr_done = 1'b1;
        cycle();
        bus.wr_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        en           = 1'b1;
        bus.wr_done  = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'h0;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        cycle();
        rst = 1'b0;

        checkOutput("rst_st_rdy",   64'(bus.st_rdy),   64'd1);
        checkOutput("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
        checkOutput("rst_empty",    64'(bus.empty),    64'd1);
        checkOutput("rst_ld_hit",   64'(bus.ld_hit),   64'd0);
        checkOutput("rst_ld_stall", 64'(bus.ld_stall), 64'd0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            checkOutput("idle_st_rdy",   64'(bus.st_rdy),   64'd1);
            checkOutput("idle_empty",    64'(bus.empty),    64'd1);
            checkOutput("idle_wr_valid", 64'(bus.wr_valid), 64'd0);
        end

        // Single store with en dropped while the write is being issued.
        applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        cycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("t2_wr_valid_early", 64'(bus.wr_valid), 64'd0);
        checkOutput("t2_empty_pending",  64'(bus.empty),    64'd0);
        cycle();
        checkOutput("t2_wr_valid", 64'(bus.wr_valid), 64'd1);
        checkOutput("t2_wr_addr",  64'(bus.wr_addr),  64'h100);
        checkOutput("t2_wr_data",  64'(bus.wr_data),  64'hDEADBEEF);
        checkOutput("t2_wr_mask",  64'(bus.wr_mask),  64'hF);
        en = 1'b0;
        applyStimulus(1'b1, 32'h180, 32'h12345678, 4'hF);
        cycle();
        checkOutput("t2_en_hold_valid", 64'(bus.wr_valid), 64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
        en = 1'b1;
        cycle();
        checkOutput("t2_wait_valid", 64'(bus.wr_valid), 64'd0);
        cycle();
        bus.wr_done = 1'b1;
        cycle();
        bus.wr_done = 1'b0;
        checkOutput("t2_empty_done",  64'(bus.empty),    64'd1);
        checkOutput("t2_st_rdy_done", 64'(bus.st_rdy),   64'd1);
        checkOutput("t2_valid_done",  64'(bus.wr_valid), 64'd0);

        // Fill to depth, fifth store refused until a pop, drain order with wrap.
        issued.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h400 + 32'(4 * i), 32'(i + 1), 4'hF);
            checkOutput("t3_st_rdy_fill", 64'(bus.st_rdy), 64'd1);
            cycle();
        end
        applyStimulus(1'b1, 32'h410, 32'd5, 4'hF);
        checkOutput("t3_st_rdy_full", 64'(bus.st_rdy), 64'd0);
        cycle();
        checkOutput("t3_st_rdy_still_full", 64'(bus.st_rdy), 64'd0);
        bus.wr_done = 1'b1;
        cycle();
        bus.wr_done = 1'b0;
        checkOutput("t3_st_rdy_after_pop", 64'(bus.st_rdy), 64'd1);
        cycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("t3_full_again", 64'(bus.st_rdy), 64'd0);
        bus.wr_done = 1'b1;
        cycle();
        bus.wr_done = 1'b0;
        finishWrite("t3_e3");
        finishWrite("t3_e4");
        finishWrite("t3_e5");
        checkOutput("t3_empty", 64'(bus.empty), 64'd1);
        checkOutput("t3_issue_count", 64'(issued.size()), 64'd5);
        for (int k = 0; k < 5 && k < issued.size(); k++) begin
            checkOutput("t3_order", issued[k], {32'h400 + 32'(4 * k), 32'(k + 1)});
        end

        // Two stores to the same word: the younger one governs the probe.
        applyStimulus(1'b1, 32'h200, 32'h11111111, 4'hF);
        cycle();
        applyStimulus(1'b1, 32'h200, 32'h22222222, 4'hF);
        cycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
`ifdef STORE_BUF_FWD_EN
        probe("t4_young", 1'b1, 32'h203, 1'b1, 32'h22222222, 1'b0);
`else
        probe("t4_young", 1'b1, 32'h203, 1'b0, 32'h0, 1'b1);
`endif
        probe("t4_novalid", 1'b0, 32'h200, 1'b0, 32'h0, 1'b0);
        finishWrite("t4_a");
`ifdef STORE_BUF_FWD_EN
        probe("t4_head", 1'b1, 32'h200, 1'b1, 32'h22222222, 1'b0);
`else
        probe("t4_head", 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
`endif
        finishWrite("t4_b");
        checkOutput("t4_empty", 64'(bus.empty), 64'd1);
        probe("t4_drained", 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);

        // Partial-mask store always stalls a matching probe.
        applyStimulus(1'b1, 32'h300, 32'hAAAA5555, 4'b0011);
        cycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
        probe("t5_partial", 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
        probe("t5_other",   1'b1, 32'h304, 1'b0, 32'h0, 1'b0);
        finishWrite("t5");
        checkOutput("t5_empty", 64'(bus.empty), 64'd1);

        // Reset while a write is outstanding; the late response must be ignored.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h500 + 32'(4 * i), 32'h50 + 32'(i), 4'hF);
            cycle();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("t6_wait_valid", 64'(bus.wr_valid), 64'd0);
        checkOutput("t6_busy",       64'(bus.empty),    64'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checkOutput("t6_rst_empty",  64'(bus.empty),    64'd1);
        checkOutput("t6_rst_st_rdy", 64'(bus.st_rdy),   64'd1);
        checkOutput("t6_rst_valid",  64'(bus.wr_valid), 64'd0);
        probe("t6_rst_probe", 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
        bus.wr_done = 1'b1;
        cycle();
        bus.wr_done = 1'b0;
        checkOutput("t6_late_empty",  64'(bus.empty),  64'd1);
        checkOutput("t6_late_st_rdy", 64'(bus.st_rdy), 64'd1);
        issued.delete();
        applyStimulus(1'b1, 32'h600, 32'h66666666, 4'hF);
        cycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("t6_new_pending", 64'(bus.empty), 64'd0);
        finishWrite("t6_new");
        checkOutput("t6_final_empty", 64'(bus.empty), 64'd1);
        checkOutput("t6_issue_count", 64'(issued.size()), 64'd1);
        if (issued.size() > 0) begin
            checkOutput("t6_new_write", issued[0], {32'h600, 32'h66666666});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
